// File: rtl/conv_job_if.sv
// conv_job_if: requester/processor bundle of conv_job_arbiter.
// master = requesters + conv_processor side, slave = arbiter side.
interface conv_job_if #(
  parameter int SIZE_W = 5,
  parameter int CNT_W  = 8
);
  logic [1:0]        req_i;
  logic [SIZE_W-1:0] sizeX0_i;
  logic [SIZE_W-1:0] sizeY0_i;
  logic [SIZE_W-1:0] sizeX1_i;
  logic [SIZE_W-1:0] sizeY1_i;
  logic [1:0]        ack_o;
  logic [1:0]        err_o;
  logic              owner_o;
  logic              busy_o;
  logic [SIZE_W-1:0] sizeX_o;
  logic [SIZE_W-1:0] sizeY_o;
  logic              start_o;
  logic              conv_busy_i;
  logic              conv_done_i;
  logic [CNT_W-1:0]  jobs_done_o;

  modport master (
    output req_i, sizeX0_i, sizeY0_i,
    output sizeX1_i, sizeY1_i,
    output conv_busy_i, conv_done_i,
    input  ack_o, err_o, owner_o, busy_o,
    input  sizeX_o, sizeY_o, start_o,
    input  jobs_done_o
  );

  modport slave (
    input  req_i, sizeX0_i, sizeY0_i,
    input  sizeX1_i, sizeY1_i,
    input  conv_busy_i, conv_done_i,
    output ack_o, err_o, owner_o, busy_o,
    output sizeX_o, sizeY_o, start_o,
    output jobs_done_o
  );
endinterface

// File: rtl/conv_job_arbiter.sv
// conv_job_arbiter: round-robin sharing of one conv_processor
// between two requesters, with size check and job watchdog.
// Ports: clk, rstn (async active-low), bus (conv_job_if.slave):
//   req_i/sizeX*_i/sizeY*_i from requesters, ack_o/err_o back,
//   owner_o/busy_o/sizeX_o/sizeY_o/start_o to processor + muxes,
//   conv_busy_i/conv_done_i from processor, jobs_done_o count.
module conv_job_arbiter #(
  parameter int SIZE_W      = 5,
  parameter int WDOG_CYCLES = 4095,
  parameter int CNT_W       = 8
) (
  input logic       clk,
  input logic       rstn,
  conv_job_if.slave bus
);
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, REJECT, START, WAIT, DONE, ABORT
  } state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [1:0]        armed_q, armed_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [SIZE_W-1:0] sx_q, sx_d;
  logic [SIZE_W-1:0] sy_q, sy_d;
  logic [CNT_W-1:0]  jobs_q, jobs_d;

  logic [1:0]        elig;
  logic              win;
  logic [SIZE_W-1:0] win_x, win_y;

  always_comb begin
    elig  = bus.req_i & armed_q;
    win   = (elig == 2'b11) ? prio_q : elig[1];
    win_x = win ? bus.sizeX1_i : bus.sizeX0_i;
    win_y = win ? bus.sizeY1_i : bus.sizeY0_i;
  end

  // Outputs are flops loaded on entry to a state, so
  // start/ack/err are visible during START/DONE/REJECT/ABORT.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    armed_d = armed_q | ~bus.req_i;
    wdog_d  = wdog_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    jobs_d  = jobs_q;
    start_d = 1'b0;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          owner_d = win;
          sx_d    = win_x;
          sy_d    = win_y;
          busy_d  = 1'b1;
          if (win_x == '0 || win_y == '0) begin
            state_d      = REJECT;
            err_d[win]   = 1'b1;
            prio_d       = ~win;
            armed_d[win] = 1'b0;
          end else begin
            state_d = START;
            start_d = 1'b1;
          end
        end
      end
      REJECT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      START: begin
        state_d = WAIT;
        wdog_d  = '0;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // done wins over a same-cycle watchdog expiry
        if (bus.conv_done_i) begin
          state_d          = DONE;
          ack_d[owner_q]   = 1'b1;
          jobs_d           = jobs_q + 1'b1;
          prio_d           = ~owner_q;
          armed_d[owner_q] = 1'b0;
        end else if (wdog_q == WD_MAX) begin
          state_d          = ABORT;
          err_d[owner_q]   = 1'b1;
          prio_d           = ~owner_q;
          armed_d[owner_q] = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      ABORT: begin
        // hold off until the stuck processor settles
        if (!bus.conv_busy_i && !bus.conv_done_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      armed_q <= 2'b11;
      wdog_q  <= '0;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      sx_q    <= '0;
      sy_q    <= '0;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      armed_q <= armed_d;
      wdog_q  <= wdog_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      jobs_q  <= jobs_d;
    end
  end

  assign bus.ack_o       = ack_q;
  assign bus.err_o       = err_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = busy_q;
  assign bus.start_o     = start_q;
  assign bus.sizeX_o     = sx_q;
  assign bus.sizeY_o     = sy_q;
  assign bus.jobs_done_o = jobs_q;
endmodule
